// File: rtl/samp_iter_ctl.sv
// Sample-iteration controller: walks a snapped bounding box in raster order,
// issuing four x-adjacent subsample positions per group with per-lane valid bits.
//
// state | meaning
// IDLE  | no box held; ready to accept a new box
// ITER  | presenting a valid sample group for the current box
module samp_iter_ctl #(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [1:0][1:0][SIGFIG-1:0]    box_R13S,
    input  logic [3:0]                     subSample_RnnnnU,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [1:0][3:0][SIGFIG-1:0]    sample_R14S,
    output logic [3:0]                     validSamp_R14H,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           last_R14H,
    output logic                           tri_done,
    output logic [31:0]                    grp_count
);

    localparam int W = SIGFIG + 2;

    typedef enum logic {
        IDLE = 1'b0,
        ITER = 1'b1
    } state_t;

    state_t state, state_n;

    logic signed [W-1:0] cur_x, cur_y, ll_x, ur_x, ur_y, step;
    logic signed [W-1:0] cx_n, cy_n, llx_n, urx_n, ury_n, step_n;
    logic signed [W-1:0] in_llx, in_lly, in_urx, in_ury, in_step;
    logic signed [W-1:0] lane_x [4];
    logic signed [W-1:0] acc;
    logic [1:0]          ss_lg2;
    logic                adv_x, adv_x_n, adv_y_n, last_n, tri_n;
    logic [3:0]          mask_n;
    logic                fire, accept, box_ok;

    // Widened copies so comparisons near the top of the range cannot wrap.
    assign in_llx = {{2{box_R13S[0][0][SIGFIG-1]}}, box_R13S[0][0]};
    assign in_lly = {{2{box_R13S[0][1][SIGFIG-1]}}, box_R13S[0][1]};
    assign in_urx = {{2{box_R13S[1][0][SIGFIG-1]}}, box_R13S[1][0]};
    assign in_ury = {{2{box_R13S[1][1][SIGFIG-1]}}, box_R13S[1][1]};

    always_comb begin
        ss_lg2 = 2'd0;
        if (subSample_RnnnnU[0])      ss_lg2 = 2'd3;
        else if (subSample_RnnnnU[1]) ss_lg2 = 2'd2;
        else if (subSample_RnnnnU[2]) ss_lg2 = 2'd1;
        in_step = W'(1) << (RADIX - int'(ss_lg2));
    end

    assign out_valid = (state == ITER);
    assign fire      = out_valid && out_ready;
    assign in_ready  = (state == IDLE) || (fire && last_R14H);
    assign accept    = in_valid && in_ready;
    assign box_ok    = (in_llx <= in_urx) && (in_lly <= in_ury);

    always_comb begin
        state_n = state;
        cx_n    = cur_x;
        cy_n    = cur_y;
        llx_n   = ll_x;
        urx_n   = ur_x;
        ury_n   = ur_y;
        step_n  = step;
        tri_n   = 1'b0;
        if (fire) begin
            if (adv_x) begin
                cx_n = cur_x + (step << 2);
            end else if (!last_R14H) begin
                cx_n = ll_x;
                cy_n = cur_y + step;
            end else begin
                state_n = IDLE;
                tri_n   = 1'b1;
            end
        end
        // A degenerate box is consumed without changing the walk.
        if (accept && box_ok) begin
            state_n = ITER;
            cx_n    = in_llx;
            cy_n    = in_lly;
            llx_n   = in_llx;
            urx_n   = in_urx;
            ury_n   = in_ury;
            step_n  = in_step;
        end
    end

    // Next group's lanes and framing, so every output can be registered.
    always_comb begin
        acc = cx_n;
        mask_n = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            lane_x[i] = acc;
            mask_n[i] = (acc <= urx_n);
            acc = acc + step_n;
        end
        adv_x_n = (cx_n + (step_n << 2)) <= urx_n;
        adv_y_n = (cy_n + step_n) <= ury_n;
        last_n  = !adv_x_n && !adv_y_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cur_x          <= '0;
            cur_y          <= '0;
            ll_x           <= '0;
            ur_x           <= '0;
            ur_y           <= '0;
            step           <= '0;
            adv_x          <= 1'b0;
            last_R14H      <= 1'b0;
            validSamp_R14H <= 4'b0000;
            sample_R14S    <= '0;
            tri_done       <= 1'b0;
            grp_count      <= '0;
        end else begin
            state     <= state_n;
            cur_x     <= cx_n;
            cur_y     <= cy_n;
            ll_x      <= llx_n;
            ur_x      <= urx_n;
            ur_y      <= ury_n;
            step      <= step_n;
            adv_x     <= adv_x_n;
            tri_done  <= tri_n;
            if (state_n == ITER) begin
                last_R14H      <= last_n;
                validSamp_R14H <= mask_n;
                for (int i = 0; i < 4; i++) begin
                    sample_R14S[0][i] <= lane_x[i][SIGFIG-1:0];
                    sample_R14S[1][i] <= cy_n[SIGFIG-1:0];
                end
            end else begin
                last_R14H      <= 1'b0;
                validSamp_R14H <= 4'b0000;
            end
            if (fire) grp_count <= grp_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_samp_iter_ctl.sv
// Bench for samp_iter_ctl: directed boxes plus randomized traffic, checked each
// cycle against a queue of expected groups generated by nested raster loops.
module tb_samp_iter_ctl;

    localparam int     SIGFIG = 24;
    localparam int     RADIX  = 10;
    localparam longint MSK    = 64'h0000_0000_00FF_FFFF;

    logic                        clk = 1'b0;
    logic                        rst;
    logic [1:0][1:0][SIGFIG-1:0] box_R13S;
    logic [3:0]                  subSample_RnnnnU;
    logic                        in_valid;
    logic                        in_ready;
    logic [1:0][3:0][SIGFIG-1:0] sample_R14S;
    logic [3:0]                  validSamp_R14H;
    logic                        out_valid;
    logic                        out_ready;
    logic                        last_R14H;
    logic                        tri_done;
    logic [31:0]                 grp_count;

    samp_iter_ctl #(.SIGFIG(SIGFIG), .RADIX(RADIX)) dut (
        .clk              (clk),
        .rst              (rst),
        .box_R13S         (box_R13S),
        .subSample_RnnnnU (subSample_RnnnnU),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .sample_R14S      (sample_R14S),
        .validSamp_R14H   (validSamp_R14H),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .last_R14H        (last_R14H),
        .tri_done         (tri_done),
        .grp_count        (grp_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint   x0;
        longint   y;
        longint   step;
        logic [3:0] mask;
        bit       last;
    } grp_t;

    grp_t        q[$];
    logic [31:0] exp_cnt;
    bit          exp_tri;
    bit          last_accept;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lg2_of(input logic [3:0] mode);
        case (mode)
            4'b0001: return 3;
            4'b0010: return 2;
            4'b0100: return 1;
            default: return 0;
        endcase
    endfunction

    // Expected groups of a box: rows of y, and within each row groups of 4 lanes.
    function automatic void push_box(input logic [3:0] mode, input longint llx, input longint lly,
                                     input longint urx, input longint ury);
        longint st = longint'(1) << (RADIX - lg2_of(mode));
        grp_t g;
        for (longint y = lly; y <= ury; y += st) begin
            for (longint x = llx; x <= urx; x += 4 * st) begin
                g.x0 = x;
                g.y = y;
                g.step = st;
                for (int i = 0; i < 4; i++) g.mask[i] = (x + i * st <= urx);
                g.last = (x + 4 * st > urx) && (y + st > ury);
                q.push_back(g);
            end
        end
    endfunction

    function automatic bit model_ready();
        return (q.size() == 0) || (out_ready && q[0].last);
    endfunction

    task automatic check_outputs();
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        chk("in_ready", 64'(in_ready), 64'(model_ready()));
        chk("tri_done", 64'(tri_done), 64'(exp_tri));
        chk("grp_count", 64'(grp_count), 64'(exp_cnt));
        if (q.size() > 0) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("x%0d", i), 64'(sample_R14S[0][i]), 64'((q[0].x0 + i * q[0].step) & MSK));
                chk($sformatf("y%0d", i), 64'(sample_R14S[1][i]), 64'(q[0].y & MSK));
            end
            chk("mask", 64'(validSamp_R14H), 64'(q[0].mask));
            chk("last", 64'(last_R14H), 64'(q[0].last));
        end
    endtask

    task automatic model_edge();
        bit fire = (q.size() > 0) && out_ready;
        bit rdy  = model_ready();
        bit nt   = 1'b0;
        last_accept = in_valid && rdy;
        if (fire) begin
            nt = q[0].last;
            void'(q.pop_front());
            exp_cnt = exp_cnt + 32'd1;
        end
        if (last_accept)
            push_box(subSample_RnnnnU,
                     longint'($signed(box_R13S[0][0])), longint'($signed(box_R13S[0][1])),
                     longint'($signed(box_R13S[1][0])), longint'($signed(box_R13S[1][1])));
        exp_tri = nt;
    endtask

    task automatic cyc();
        @(negedge clk);
        check_outputs();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_box(input logic [3:0] mode, input int llx, input int lly, input int urx, input int ury);
        subSample_RnnnnU = mode;
        box_R13S[0][0] = llx[SIGFIG-1:0];
        box_R13S[0][1] = lly[SIGFIG-1:0];
        box_R13S[1][0] = urx[SIGFIG-1:0];
        box_R13S[1][1] = ury[SIGFIG-1:0];
    endtask

    task automatic send_box(input logic [3:0] mode, input int llx, input int lly, input int urx, input int ury);
        int n = 0;
        set_box(mode, llx, lly, urx, ury);
        in_valid = 1'b1;
        do begin
            cyc();
            n++;
        end while (!last_accept && n < 300);
        chk("box_accepted", 64'(last_accept), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() > 0 || exp_tri) && n < 500) begin
            cyc();
            n++;
        end
        chk("drained", 64'(q.size() == 0 && !exp_tri), 64'(1));
        cyc();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
        chk({tag, "_last"}, 64'(last_R14H), 64'(0));
        chk({tag, "_tri_done"}, 64'(tri_done), 64'(0));
        chk({tag, "_mask"}, 64'(validSamp_R14H), 64'(0));
        chk({tag, "_sample"}, 64'(sample_R14S != '0), 64'(0));
        chk({tag, "_grp_count"}, 64'(grp_count), 64'(0));
    endtask

    task automatic rand_box();
        int m  = int'($urandom_range(0, 3));
        int st = 1 << (RADIX - lg2_of(4'b0001 << m));
        int llx = (int'($urandom_range(0, 200)) - 100) * st;
        int lly = (int'($urandom_range(0, 200)) - 100) * st;
        int urx = llx + (int'($urandom_range(0, 9)) - 1) * st;
        int ury = lly + (int'($urandom_range(0, 6)) - 1) * st;
        set_box(4'b0001 << m, llx, lly, urx, ury);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        box_R13S = '0;
        subSample_RnnnnU = 4'b1000;
        exp_cnt = '0;
        exp_tri = 1'b0;
        last_accept = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst = 1'b0;
        cyc();

        send_box(4'b1000, 0, 0, 0, 0);
        drain();
        send_box(4'b1000, 1024, 2048, 7168, 3072);
        drain();
        send_box(4'b0010, 0, 0, 256, 256);
        drain();

        // Stall for three cycles in the middle of a box.
        send_box(4'b1000, 1024, 2048, 7168, 3072);
        cyc();
        out_ready = 1'b0;
        repeat (3) cyc();
        out_ready = 1'b1;
        drain();

        // Second box held while the first one's last group is consumed.
        send_box(4'b1000, 0, 0, 4096, 1024);
        send_box(4'b0100, -512, -512, 512, 0);
        drain();

        send_box(4'b1000, 1024, 0, 0, 0);
        drain();
        send_box(4'b1000, 0, 1024, 0, 0);
        drain();

        // Near the positive limit of the coordinate range.
        send_box(4'b1000, 8385536, 0, 8387584, 0);
        drain();

        // Asynchronous reset while iterating.
        send_box(4'b1000, 0, 0, 8192, 4096);
        cyc();
        cyc();
        #2 rst = 1'b1;
        #1 check_reset_vals("midreset");
        q.delete();
        exp_cnt = '0;
        exp_tri = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        cyc();
        send_box(4'b0001, 0, 0, 128, 0);
        drain();

        for (int c = 0; c < 1500; c++) begin
            if (!in_valid) begin
                if ($urandom_range(0, 9) < 6) begin
                    rand_box();
                    in_valid = 1'b1;
                end else begin
                    subSample_RnnnnU = 4'($urandom);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cyc();
            if (last_accept) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
